// File: rtl/led_pwm_fader.sv
// PWM output stage for the blink-timer LED: turns the 1-bit LED state into a PWM duty that ramps per PWM period.
// Build option: define LED_PWM_FADE_EN for the ramp state machine; without it DUTY jumps straight to target.
module led_pwm_fader #(
  parameter int          PWM_BITS  = 8,
  parameter logic [15:0] PRESC_MAX = 16'd49,
  parameter int          FADE_STEP = 8
) (
  input  logic                CLK_50M,
  input  logic                RST_N,
  input  logic                LED_IN,
  input  logic [PWM_BITS-1:0] BRIGHT,
  output logic                LED_PWM,
  output logic [PWM_BITS-1:0] DUTY,
  output logic                FADE_BUSY
);

  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
  localparam logic [PWM_BITS-1:0] PWM_ONE  = PWM_BITS'(1);

  if (FADE_STEP < 1 || FADE_STEP > (2 ** PWM_BITS) - 1) begin : g_step_range
    $fatal(1, "FADE_STEP outside 1..2^PWM_BITS-1");
  end

  logic [15:0]         presc_cnt;
  logic                tick;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                pbound;
  logic [PWM_BITS-1:0] target;

  assign tick   = (presc_cnt == PRESC_MAX);
  assign pbound = tick && (pwm_cnt == DUTY_MAX);
  assign target = LED_IN ? BRIGHT : '0;

  // NOTE: every clocked register uses non-blocking assignment so all flops sample pre-edge values together.
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      presc_cnt <= '0;
    end else if (tick) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + 16'd1;
    end
  end

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      pwm_cnt <= '0;
    end else if (tick) begin
      pwm_cnt <= pwm_cnt + PWM_ONE;
    end
  end

  // Full-scale duty would otherwise leave one low count per period.
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      LED_PWM <= 1'b0;
    end else begin
      LED_PWM <= (DUTY == DUTY_MAX) || (pwm_cnt < DUTY);
    end
  end

`ifdef LED_PWM_FADE_EN

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RISE = 2'd1,
    FALL = 2'd2
  } state_t;

  localparam logic [PWM_BITS:0] STEP = (PWM_BITS + 1)'(FADE_STEP);

  state_t              state;
  state_t              state_nxt;
  logic [PWM_BITS:0]   tgt_w;
  logic [PWM_BITS:0]   duty_w;
  logic [PWM_BITS:0]   up_gap;
  logic [PWM_BITS:0]   down_gap;
  logic [PWM_BITS:0]   rise_duty;
  logic [PWM_BITS:0]   fall_duty;
  logic [PWM_BITS:0]   duty_nxt;

  // One extra bit of headroom; a step is clamped to target whenever the gap fits inside it.
  assign tgt_w     = {1'b0, target};
  assign duty_w    = {1'b0, DUTY};
  assign up_gap    = tgt_w - duty_w;
  assign down_gap  = duty_w - tgt_w;
  assign rise_duty = (up_gap <= STEP)   ? tgt_w : duty_w + STEP;
  assign fall_duty = (down_gap <= STEP) ? tgt_w : duty_w - STEP;

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      DUTY  <= '0;
    end else if (pbound) begin
      state <= state_nxt;
      DUTY  <= duty_nxt[PWM_BITS-1:0];
    end
  end

  // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
  always_comb begin
    state_nxt = state;
    duty_nxt  = duty_w;
    unique case (state)
      IDLE: begin
        if (target > DUTY) begin
          state_nxt = RISE;
          duty_nxt  = rise_duty;
        end else if (target < DUTY) begin
          state_nxt = FALL;
          duty_nxt  = fall_duty;
        end
      end
      RISE: begin
        if (target < DUTY) begin
          state_nxt = FALL;
          duty_nxt  = fall_duty;
        end else begin
          duty_nxt  = rise_duty;
        end
      end
      FALL: begin
        if (target > DUTY) begin
          state_nxt = RISE;
          duty_nxt  = rise_duty;
        end else begin
          duty_nxt  = fall_duty;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (duty_nxt == tgt_w) begin
      state_nxt = IDLE;
    end
  end

  always_comb begin
    FADE_BUSY = (state != IDLE);
  end

`else

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      DUTY <= '0;
    end else if (pbound) begin
      DUTY <= target;
    end
  end

  assign FADE_BUSY = 1'b0;

`endif

endmodule
